// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Hardwired control sequencer for the register-file/bus datapath. One FSM
//   walks fetch (T0-T2), decodes the IR, and issues the execute steps for the
//   binary, unary and MUL/DIV ALU register operations.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               begin one instruction (sampled only in IDLE)
//   ir[31:0]            IR contents: opcode[31:27] ra[26:23] rb[22:19] rc[18:15]
//   mem_ready           memory read data valid on the MDR input
//   busy, done          not-IDLE status, one-cycle completion pulse
//   illegal, mem_fault  sticky status until the next accepted start / reset
//   step[3:0]           IDLE=0, T0..T6=1..7, DONE=8
//   r_out, r_in         one-hot general register drive / load
//   pc_out .. hi_in     single-bit datapath strobes
//   alu_op              one-hot ALU function
//                       (AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT)
module alu_op_sequencer #(
  parameter int NUM_REGS    = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int ALU_OPS     = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                mem_fault,
  output logic [3:0]          step,
  output logic [NUM_REGS-1:0] r_out,
  output logic [NUM_REGS-1:0] r_in,
  output logic                pc_out,
  output logic                pc_in,
  output logic                inc_pc,
  output logic                mar_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic                lo_in,
  output logic                hi_in,
  output logic [ALU_OPS-1:0]  alu_op
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [7:0]   r_wait;
  logic         r_illegal;
  logic         r_mem_fault;

  logic [4:0]   w_opc;
  logic [3:0]   w_ra;
  logic [3:0]   w_rb;
  logic [3:0]   w_rc;
  logic         w_muldiv;
  logic         w_unary;
  logic         w_bad;
  logic         w_first_t1;
  logic         w_wait_last;
  logic [12:0]  w_alu_sel;
  logic         w_unused_ir;

  assign w_opc       = ir[31:27];
  assign w_ra        = ir[26:23];
  assign w_rb        = ir[22:19];
  assign w_rc        = ir[18:15];
  assign w_unused_ir = ^ir[14:0];

  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
    reg_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) reg_sel[i] = 1'b1;
    end
  endfunction

  function automatic logic idx_ok(input logic [3:0] idx);
    return {1'b0, idx} < 5'(NUM_REGS);
  endfunction

  assign w_muldiv = (w_opc == 5'd9)  || (w_opc == 5'd10);
  assign w_unary  = (w_opc == 5'd11) || (w_opc == 5'd12);

  // MUL/DIV write LO/HI rather than ra; NEG/NOT take no rc operand.
  assign w_bad = (w_opc > 5'd12) || !idx_ok(w_rb)
               || (!w_muldiv && !idx_ok(w_ra))
               || (!w_unary  && !idx_ok(w_rc));

  // The counter holds the number of T1 cycles already spent waiting.
  assign w_first_t1  = (r_wait == '0);
  assign w_wait_last = (r_wait == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    w_alu_sel = '0;
    case (w_opc)
      5'd0:    w_alu_sel[2]  = 1'b1;  // ADD
      5'd1:    w_alu_sel[3]  = 1'b1;  // SUB
      5'd2:    w_alu_sel[0]  = 1'b1;  // AND
      5'd3:    w_alu_sel[1]  = 1'b1;  // OR
      5'd4:    w_alu_sel[6]  = 1'b1;  // SHR
      5'd5:    w_alu_sel[7]  = 1'b1;  // SHRA
      5'd6:    w_alu_sel[8]  = 1'b1;  // SHL
      5'd7:    w_alu_sel[9]  = 1'b1;  // ROR
      5'd8:    w_alu_sel[10] = 1'b1;  // ROL
      5'd9:    w_alu_sel[4]  = 1'b1;  // MUL
      5'd10:   w_alu_sel[5]  = 1'b1;  // DIV
      5'd11:   w_alu_sel[11] = 1'b1;  // NEG
      5'd12:   w_alu_sel[12] = 1'b1;  // NOT
      default: w_alu_sel     = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_illegal   <= 1'b0;
      r_mem_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_illegal   <= 1'b0;
            r_mem_fault <= 1'b0;
          end
        end
        S_T0: r_wait <= '0;
        S_T1: begin
          if (!mem_ready) begin
            if (w_wait_last) r_mem_fault <= 1'b1;
            else             r_wait      <= r_wait + 8'd1;
          end
        end
        S_T3: begin
          if (w_bad) r_illegal <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    r_out     = '0;
    r_in      = '0;
    pc_out    = 1'b0;
    pc_in     = 1'b0;
    inc_pc    = 1'b0;
    mar_in    = 1'b0;
    read      = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    lo_in     = 1'b0;
    hi_in     = 1'b0;
    alu_op    = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_T0;
      end
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = w_first_t1;
        read     = 1'b1;
        mdr_in   = 1'b1;
        if (mem_ready)        w_next = S_T2;
        else if (w_wait_last) w_next = S_DONE;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        w_next  = S_T3;
      end
      S_T3: begin
        if (w_bad) begin
          w_next = S_DONE;
        end else if (w_unary) begin
          r_out  = reg_sel(w_rb);
          alu_op = ALU_OPS'(w_alu_sel);
          z_in   = 1'b1;
          w_next = S_T4;
        end else begin
          r_out  = reg_sel(w_rb);
          y_in   = 1'b1;
          w_next = S_T4;
        end
      end
      S_T4: begin
        if (w_unary) begin
          zlow_out = 1'b1;
          r_in     = reg_sel(w_ra);
          w_next   = S_DONE;
        end else begin
          r_out  = reg_sel(w_rc);
          alu_op = ALU_OPS'(w_alu_sel);
          z_in   = 1'b1;
          w_next = S_T5;
        end
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (w_muldiv) begin
          lo_in  = 1'b1;
          w_next = S_T6;
        end else begin
          r_in   = reg_sel(w_ra);
          w_next = S_DONE;
        end
      end
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        w_next    = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign step      = r_state;
  assign illegal   = r_illegal;
  assign mem_fault = r_mem_fault;

endmodule
